// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, state encoding and command decode shared by the SPI flash responder
package spi_flash_pkg;
    localparam int BYTE_BITS = 8;
    localparam logic [BYTE_BITS-1:0] CMD_READ = 8'h03;
    localparam logic [BYTE_BITS-1:0] CMD_RDID = 8'h9F;
    localparam logic [BYTE_BITS-1:0] CMD_RDSR = 8'h05;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;
    function automatic state_t decode_cmd(input logic [BYTE_BITS-1:0] op);
        return (op == CMD_READ) ? ADDR : (op == CMD_RDID) ? ID : (op == CMD_RDSR) ? STAT : IGNORE;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes sclk/ss/mosi into io_clock and flags sclk and ss edges
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic io_clock,
    input  logic io_reset,
    input  logic i_sclk,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_ss,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_ss_fall,
    output logic o_ss_rise
);
    logic [SYNC_STAGES-1:0] r_sclk, r_ss, r_mosi;
    logic r_sclk_d, r_ss_d;
    logic w_sclk;
    // ss resets high so a reset never looks like the start of a transfer
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            r_sclk   <= '0;
            r_ss     <= '1;
            r_mosi   <= '0;
            r_sclk_d <= 1'b0;
            r_ss_d   <= 1'b1;
        end else begin
            r_sclk   <= (r_sclk << 1) | SYNC_STAGES'(i_sclk);
            r_ss     <= (r_ss << 1) | SYNC_STAGES'(i_ss);
            r_mosi   <= (r_mosi << 1) | SYNC_STAGES'(i_mosi);
            r_sclk_d <= w_sclk;
            r_ss_d   <= o_ss;
        end
    end
    assign w_sclk      = r_sclk[SYNC_STAGES-1];
    assign o_ss        = r_ss[SYNC_STAGES-1];
    assign o_mosi      = r_mosi[SYNC_STAGES-1];
    assign o_sclk_rise = w_sclk & ~r_sclk_d;
    assign o_sclk_fall = ~w_sclk & r_sclk_d;
    assign o_ss_fall   = ~o_ss & r_ss_d;
    assign o_ss_rise   = o_ss & ~r_ss_d;
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI target answering READ/RDID/RDSR, READ data fetched over a req/valid byte port
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int              SYNC_STAGES  = 2,
    parameter int              ADDR_WIDTH   = 24,
    parameter logic [23:0]     JEDEC_ID     = 24'hEF4016,
    parameter logic [7:0]      STATUS_VALUE = 8'h00
) (
    input  logic                  io_clock,
    input  logic                  io_reset,
    input  logic                  io_spi_sclk,
    input  logic                  io_spi_ss,
    input  logic                  io_spi_mosi,
    output logic                  io_spi_miso,
    output logic                  io_spi_miso_oe,
    output logic                  io_mem_req,
    output logic [ADDR_WIDTH-1:0] io_mem_addr,
    input  logic                  io_mem_valid,
    input  logic [7:0]            io_mem_data,
    output logic                  io_busy,
    output logic                  io_underrun,
    input  logic                  io_clear_underrun
);
    localparam int CW = $clog2((ADDR_WIDTH > BYTE_BITS ? ADDR_WIDTH : BYTE_BITS) + 1);
    logic w_ss, w_mosi, w_rise, w_fall, w_ss_fall, w_ss_rise;
    state_t r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_in, w_in_next, r_mem_addr;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0] r_out_cnt;
    logic [1:0] r_id_idx;
    logic [7:0] r_shift, r_buf, w_id_byte, w_byte;
    logic r_miso, r_oe, r_req, r_out, r_buf_valid, r_underrun, r_busy;
    logic w_cmd_last, w_addr_last, w_out_state, w_byte_start, w_underrun_set;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .io_clock    (io_clock),
        .io_reset    (io_reset),
        .i_sclk      (io_spi_sclk),
        .i_ss        (io_spi_ss),
        .i_mosi      (io_spi_mosi),
        .o_ss        (w_ss),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall),
        .o_ss_fall   (w_ss_fall),
        .o_ss_rise   (w_ss_rise)
    );

    assign w_in_next      = {r_in[ADDR_WIDTH-2:0], w_mosi};
    assign w_cmd_last     = (r_state == CMD) && w_rise && (r_bit_cnt == CW'(BYTE_BITS - 1));
    assign w_addr_last    = (r_state == ADDR) && w_rise && (r_bit_cnt == CW'(ADDR_WIDTH - 1));
    assign w_out_state    = (r_state == DATA) || (r_state == ID) || (r_state == STAT);
    assign w_byte_start   = w_out_state && w_fall && (r_out_cnt == 3'd0) && !w_ss;
    assign w_underrun_set = w_byte_start && (r_state == DATA) && !r_buf_valid;
    assign w_id_byte      = (r_id_idx == 2'd0) ? JEDEC_ID[23:16] : (r_id_idx == 2'd1) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
    assign w_byte         = (r_state == ID) ? w_id_byte : (r_state == STAT) ? STATUS_VALUE : (r_buf_valid ? r_buf : 8'h00);

    always_ff @(posedge io_clock) begin
        if (io_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_ss) w_next = IDLE;
        else if (r_state == IDLE && w_ss_fall) w_next = CMD;
        else if (w_cmd_last) w_next = decode_cmd(w_in_next[BYTE_BITS-1:0]);
        else if (w_addr_last) w_next = DATA;
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            r_in        <= '0;
            r_mem_addr  <= '0;
            r_bit_cnt   <= '0;
            r_out_cnt   <= '0;
            r_id_idx    <= '0;
            r_shift     <= '0;
            r_buf       <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_req       <= 1'b0;
            r_out       <= 1'b0;
            r_buf_valid <= 1'b0;
        end else if (w_ss) begin
            // deselect aborts everything, including a fetch still in flight
            r_bit_cnt   <= '0;
            r_out_cnt   <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_req       <= 1'b0;
            r_out       <= 1'b0;
            r_buf_valid <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (r_state == IDLE && w_ss_fall) begin
                r_in      <= '0;
                r_bit_cnt <= '0;
                r_out_cnt <= '0;
                r_id_idx  <= '0;
                r_shift   <= '0;
            end
            if (w_rise && (r_state == CMD || r_state == ADDR)) begin
                r_in      <= w_in_next;
                r_bit_cnt <= (w_cmd_last || w_addr_last) ? '0 : r_bit_cnt + CW'(1);
            end
            if (w_addr_last) begin
                r_req      <= 1'b1;
                r_mem_addr <= w_in_next;
                r_out      <= 1'b1;
            end
            if (io_mem_valid && r_out) begin
                r_buf       <= io_mem_data;
                r_buf_valid <= 1'b1;
                r_out       <= 1'b0;
            end
            if (w_out_state && w_fall) begin
                r_out_cnt <= r_out_cnt + 3'd1;
                if (r_out_cnt == 3'd0) begin
                    r_miso  <= w_byte[7];
                    r_shift <= {w_byte[6:0], 1'b0};
                    r_oe    <= 1'b1;
                    r_id_idx <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
                    // consuming the buffer prefetches the next sequential byte
                    if (r_state == DATA && r_buf_valid) begin
                        r_buf_valid <= 1'b0;
                        r_req       <= 1'b1;
                        r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
                        r_out       <= 1'b1;
                    end
                end else begin
                    r_miso  <= r_shift[7];
                    r_shift <= {r_shift[6:0], 1'b0};
                end
            end
        end
    end

    // a set in the same cycle as a clear wins
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            r_underrun <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_underrun <= w_underrun_set || (r_underrun && !io_clear_underrun);
            r_busy     <= w_ss_fall ? 1'b1 : w_ss_rise ? 1'b0 : r_busy;
        end
    end

    assign io_spi_miso    = r_miso;
    assign io_spi_miso_oe = r_oe;
    assign io_mem_req     = r_req;
    assign io_mem_addr    = r_mem_addr;
    assign io_busy        = r_busy;
    assign io_underrun    = r_underrun;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed and randomized SPI transactions against a byte-level flash model
module tb_spi_flash_responder;
    localparam int SS = 2;
    logic io_clock = 1'b0, io_reset = 1'b1;
    logic sclk = 1'b0, ss = 1'b1, mosi = 1'b0, clr = 1'b0;
    logic mem_valid = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic miso, oe, req, busy, underrun;
    logic [23:0] mem_addr;
    int checks = 0, fails = 0, lat = 2, oe_cnt = 0, cyc = 0;
    logic [23:0] req_q[$], pend_q[$];
    int due_q[$];
    logic [7:0] ops[3] = '{8'h03, 8'h9F, 8'h05};

    spi_flash_responder #(.SYNC_STAGES(SS)) dut (
        .io_clock          (io_clock),
        .io_reset          (io_reset),
        .io_spi_sclk       (sclk),
        .io_spi_ss         (ss),
        .io_spi_mosi       (mosi),
        .io_spi_miso       (miso),
        .io_spi_miso_oe    (oe),
        .io_mem_req        (req),
        .io_mem_addr       (mem_addr),
        .io_mem_valid      (mem_valid),
        .io_mem_data       (mem_data),
        .io_busy           (busy),
        .io_underrun       (underrun),
        .io_clear_underrun (clr)
    );

    always #5 io_clock = ~io_clock;

    // memory: each request answered lat cycles later with addr[7:0]^0xA5
    initial forever begin
        logic [23:0] a;
        @(negedge io_clock);
        cyc++;
        mem_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            a = pend_q.pop_front();
            void'(due_q.pop_front());
            mem_valid = 1'b1;
            mem_data = a[7:0] ^ 8'hA5;
        end
        if (req) begin
            req_q.push_back(mem_addr);
            pend_q.push_back(mem_addr);
            due_q.push_back(cyc + lat);
        end
        if (oe) oe_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] a, input int i);
        logic [23:0] x;
        if (op == 8'h03) begin
            x = a + 24'(i);
            return x[7:0] ^ 8'hA5;
        end
        if (op == 8'h9F) begin
            x = 24'hEF4016 >> (16 - 8 * (i % 3));
            return x[7:0];
        end
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_start(input int h);
        ss = 1'b0;
        repeat (h) @(negedge io_clock);
    endtask

    task automatic spi_end(input int h);
        repeat (h) @(negedge io_clock);
        ss = 1'b1;
        repeat (2 * h + 8) @(negedge io_clock);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, input int h, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b >= 8 - n; b--) begin
            mosi = tx[b];
            repeat (h) @(negedge io_clock);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (h) @(negedge io_clock);
            sclk = 1'b0;
        end
    endtask

    // the final falling edge of the last byte starts one more byte, which prefetches addr+nb+1
    task automatic run_cmd(input logic [7:0] op, input logic [23:0] a, input int nb, input int h);
        logic [7:0] rx;
        logic [23:0] ea;
        int n0;
        n0 = req_q.size();
        spi_start(h);
        chk("busy_active", busy, 1);
        spi_bits(op, 8, h, rx);
        if (op == 8'h03) begin
            spi_bits(a[23:16], 8, h, rx);
            spi_bits(a[15:8], 8, h, rx);
            spi_bits(a[7:0], 8, h, rx);
        end
        for (int i = 0; i < nb; i++) begin
            spi_bits(8'h00, 8, h, rx);
            chk($sformatf("rx_op%02h_byte%0d", op, i), rx, exp_byte(op, a, i));
        end
        spi_end(h);
        chk("busy_idle", busy, 0);
        if (op == 8'h03) begin
            chk("req_count", req_q.size(), n0 + nb + 2);
            for (int i = 0; i <= nb; i++) begin
                ea = a + 24'(i);
                chk($sformatf("req_addr%0d", i), req_q[n0 + i], ea);
            end
        end else chk("no_req", req_q.size(), n0);
    endtask

    initial begin
        logic [7:0] rx;
        int n0, o0;
        repeat (3) @(negedge io_clock);
        chk("rst_miso", miso, 0);
        chk("rst_oe", oe, 0);
        chk("rst_req", req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        io_reset = 1'b0;
        repeat (4) @(negedge io_clock);
        // RDID with MISO drive check
        o0 = oe_cnt;
        run_cmd(8'h9F, 24'h0, 3, 8);
        chk("rdid_oe_driven", oe_cnt > o0, 1);
        run_cmd(8'h03, 24'h000010, 3, 8);
        chk("read_no_underrun", underrun, 0);
        run_cmd(8'h03, 24'hFFFFFF, 2, 8);
        // underrun: slow memory
        lat = 100;
        spi_start(4);
        spi_bits(8'h03, 8, 4, rx);
        spi_bits(8'h00, 8, 4, rx);
        spi_bits(8'h01, 8, 4, rx);
        spi_bits(8'h00, 8, 4, rx);
        spi_bits(8'h00, 8, 4, rx);
        chk("underrun_byte", rx, 8'h00);
        spi_end(4);
        chk("underrun_set", underrun, 1);
        repeat (110) @(negedge io_clock);
        chk("underrun_sticky", underrun, 1);
        clr = 1'b1;
        @(negedge io_clock);
        clr = 1'b0;
        chk("underrun_cleared", underrun, 0);
        lat = 2;
        run_cmd(8'h03, 24'h000020, 1, 8);
        chk("underrun_stays_clear", underrun, 0);
        // abort during address phase
        n0 = req_q.size();
        spi_start(8);
        spi_bits(8'h03, 8, 8, rx);
        spi_bits(8'h12, 8, 8, rx);
        spi_bits(8'h34, 4, 8, rx);
        ss = 1'b1;
        repeat (SS + 1) @(negedge io_clock);
        chk("abort_oe", oe, 0);
        chk("abort_busy", busy, 0);
        repeat (20) @(negedge io_clock);
        chk("abort_no_req", req_q.size(), n0);
        run_cmd(8'h05, 24'h0, 1, 8);
        // abort mid-RDID while MISO is driven
        spi_start(8);
        spi_bits(8'h9F, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        chk("rdid_abort_byte0", rx, 8'hEF);
        spi_bits(8'h00, 4, 8, rx);
        chk("rdid_abort_oe_before", oe, 1);
        ss = 1'b1;
        repeat (SS + 1) @(negedge io_clock);
        chk("rdid_abort_oe_after", oe, 0);
        chk("rdid_abort_miso", miso, 0);
        repeat (20) @(negedge io_clock);
        // unknown opcode
        o0 = oe_cnt;
        spi_start(8);
        spi_bits(8'hAB, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        spi_end(8);
        chk("ignore_oe", oe_cnt, o0);
        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            logic [23:0] a;
            a = (t == 0) ? 24'hFFFFFE : 24'($urandom);
            run_cmd(ops[$urandom_range(0, 2)], a, $urandom_range(1, 4), $urandom_range(5, 8));
        end
        // reset mid-READ while data is being shifted out
        spi_start(8);
        spi_bits(8'h03, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        spi_bits(8'h40, 8, 8, rx);
        spi_bits(8'h00, 8, 8, rx);
        chk("mid_read_byte", rx, 8'hE5);
        spi_bits(8'h00, 3, 8, rx);
        chk("mid_read_oe", oe, 1);
        io_reset = 1'b1;
        @(negedge io_clock);
        chk("midrst_miso", miso, 0);
        chk("midrst_oe", oe, 0);
        chk("midrst_req", req, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_underrun", underrun, 0);
        io_reset = 1'b0;
        ss = 1'b1;
        repeat (10) @(negedge io_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
